// File: rtl/lsu_pkg.sv
// Shared constants for the load/store memory stage: funct3 codes, exception codes, FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        GAP  = 3'd2,
        WR   = 3'd3,
        WB   = 3'd4
    } state_t;

    // Stores only have the three signed widths; loads add the unsigned byte/half forms.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Combinational lane logic: load byte/half extraction with extension, and store word merge.
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  logic [31:0] load_word,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lane)
            2'd0:    byte_sel = load_word[7:0];
            2'd1:    byte_sel = load_word[15:8];
            2'd2:    byte_sel = load_word[23:16];
            default: byte_sel = load_word[31:24];
        endcase
        half_sel = lane[1] ? load_word[31:16] : load_word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = load_word;
        endcase
    end

    // Sub-word stores keep the untouched lanes of the word read back during RD.
    always_comb begin
        merged = old_word;
        case (funct3)
            F3_B: begin
                case (lane)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage in front of the data-cache controller; sub-word stores use read-modify-write.
// LSU_MISALIGN_TRAP_EN: when defined, misaligned ops fault with exc 01; otherwise low address bits are forced aligned.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TMO_W          = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        read_mem,
    output logic        write_mem,
    output logic [31:0] addr,
    output logic        addr_valid,
    output logic [31:0] write_data,
    output logic        write_data_valid,
    input  logic        mem_done,
    input  logic [31:0] result,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [1:0]  wb_exc,
    output logic        busy
);

    state_t           state;
    logic [1:0]       lane_q;
    logic [2:0]       f3_q;
    logic             is_store_q;
    logic [31:0]      wdata_q;
    logic [4:0]       rd_q;
    logic [31:0]      word_q;
    logic [TMO_W-1:0] tmo_q;

    logic [31:0] ea_raw;
    logic [31:0] ea_acc;
    logic        legal;
    logic        misaligned;
    logic        tmo_expired;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign ea_raw      = req_base + req_offset;
    assign legal       = f3_legal(req_is_store, req_funct3);
    assign tmo_expired = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign req_ready   = (state == IDLE);
    assign busy        = (state != IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((req_funct3[1:0] == 2'b01) && ea_raw[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (ea_raw[1:0] != 2'b00));
    assign ea_acc     = ea_raw;
`else
    assign misaligned = 1'b0;
    always_comb begin
        ea_acc = ea_raw;
        if (req_funct3[1:0] == 2'b01) ea_acc[0]   = 1'b0;
        if (req_funct3[1:0] == 2'b10) ea_acc[1:0] = 2'b00;
    end
`endif

    lsu_lane_unit u_lane (
        .load_word (result),
        .old_word  (word_q),
        .wdata     (wdata_q),
        .lane      (lane_q),
        .funct3    (f3_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            lane_q           <= '0;
            f3_q             <= '0;
            is_store_q       <= 1'b0;
            wdata_q          <= '0;
            rd_q             <= '0;
            word_q           <= '0;
            tmo_q            <= '0;
            read_mem         <= 1'b0;
            write_mem        <= 1'b0;
            addr             <= '0;
            addr_valid       <= 1'b0;
            write_data       <= '0;
            write_data_valid <= 1'b0;
            wb_valid         <= 1'b0;
            wb_rd            <= '0;
            wb_data          <= '0;
            wb_exc           <= EXC_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lane_q     <= ea_acc[1:0];
                        f3_q       <= req_funct3;
                        is_store_q <= req_is_store;
                        wdata_q    <= req_wdata;
                        rd_q       <= req_rd;
                        tmo_q      <= '0;
                        if (!legal || misaligned) begin
                            state    <= WB;
                            wb_valid <= 1'b1;
                            wb_rd    <= '0;
                            wb_data  <= '0;
                            wb_exc   <= !legal ? EXC_ILLEGAL : EXC_MISALIGN;
                        end else if (req_is_store && (req_funct3 == F3_W)) begin
                            state            <= WR;
                            write_mem        <= 1'b1;
                            addr_valid       <= 1'b1;
                            write_data_valid <= 1'b1;
                            write_data       <= req_wdata;
                            addr             <= {ea_acc[31:2], 2'b00};
                        end else begin
                            state      <= RD;
                            read_mem   <= 1'b1;
                            addr_valid <= 1'b1;
                            addr       <= {ea_acc[31:2], 2'b00};
                        end
                    end
                end
                RD: begin
                    // mem_done wins over a coincident timeout expiry.
                    if (mem_done) begin
                        read_mem   <= 1'b0;
                        addr_valid <= 1'b0;
                        word_q     <= result;
                        if (is_store_q) begin
                            state <= GAP;
                        end else begin
                            state    <= WB;
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_q;
                            wb_data  <= load_data;
                            wb_exc   <= EXC_NONE;
                        end
                    end else if (tmo_expired) begin
                        read_mem   <= 1'b0;
                        addr_valid <= 1'b0;
                        state      <= WB;
                        wb_valid   <= 1'b1;
                        wb_rd      <= '0;
                        wb_data    <= '0;
                        wb_exc     <= EXC_TIMEOUT;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                GAP: begin
                    state            <= WR;
                    tmo_q            <= '0;
                    write_mem        <= 1'b1;
                    addr_valid       <= 1'b1;
                    write_data_valid <= 1'b1;
                    write_data       <= merged;
                end
                WR: begin
                    if (mem_done || tmo_expired) begin
                        write_mem        <= 1'b0;
                        addr_valid       <= 1'b0;
                        write_data_valid <= 1'b0;
                        state            <= WB;
                        wb_valid         <= 1'b1;
                        wb_rd            <= '0;
                        wb_data          <= '0;
                        wb_exc           <= mem_done ? EXC_NONE : EXC_TIMEOUT;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                WB: begin
                    if (wb_ready) begin
                        state    <= IDLE;
                        wb_valid <= 1'b0;
                        wb_rd    <= '0;
                        wb_data  <= '0;
                        wb_exc   <= EXC_NONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage; the bench plays the cache controller and writeback consumer.
module tb_lsu_mem_stage;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base, req_offset, req_wdata;
    logic [4:0]  req_rd;
    logic        read_mem, write_mem, addr_valid, write_data_valid;
    logic [31:0] addr, write_data;
    logic        mem_done;
    logic [31:0] result;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  wb_exc;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.TIMEOUT_CYCLES(16), .TMO_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .read_mem(read_mem), .write_mem(write_mem), .addr(addr), .addr_valid(addr_valid),
        .write_data(write_data), .write_data_valid(write_data_valid),
        .mem_done(mem_done), .result(result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_exc(wb_exc), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] wd, input logic [4:0] rd);
        req_is_store = st;
        req_funct3   = f3;
        req_base     = base;
        req_offset   = off;
        req_wdata    = wd;
        req_rd       = rd;
        req_valid    = 1'b1;
        tick();
        req_valid    = 1'b0;
    endtask

    task automatic complete(input logic [31:0] word);
        mem_done = 1'b1;
        result   = word;
        tick();
        mem_done = 1'b0;
    endtask

    task automatic handshake();
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
        req_base = '0; req_offset = '0; req_wdata = '0; req_rd = '0;
        mem_done = 1'b0; result = '0; wb_ready = 1'b0;
        tick(); tick();
        check("rst_req_ready", req_ready, 1);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_read_mem", read_mem, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // LB ea=0x1003
        issue(1'b0, F3_B, 32'h1000, 32'd3, 32'h0, 5'd5);
        check("lb_read_mem", read_mem, 1);
        check("lb_addr", addr, 32'h1000);
        check("lb_addr_valid", addr_valid, 1);
        check("lb_req_ready", req_ready, 0);
        complete(32'h80FF_1234);
        check("lb_read_drop", read_mem, 0);
        check("lb_wb_valid", wb_valid, 1);
        check("lb_wb_data", wb_data, 32'hFFFF_FF80);
        check("lb_wb_rd", wb_rd, 5);
        check("lb_wb_exc", wb_exc, EXC_NONE);
        handshake();
        check("lb_wb_done", wb_valid, 0);
        check("lb_ready_back", req_ready, 1);

        // SH ea=0x2002, read-modify-write
        issue(1'b1, F3_H, 32'h2000, 32'd2, 32'h0000_ABCD, 5'd7);
        check("sh_read_mem", read_mem, 1);
        check("sh_addr", addr, 32'h2000);
        complete(32'h1111_2222);
        check("sh_gap_read", read_mem, 0);
        check("sh_gap_write", write_mem, 0);
        check("sh_gap_av", addr_valid, 0);
        tick();
        check("sh_wr_write", write_mem, 1);
        check("sh_wr_wdv", write_data_valid, 1);
        check("sh_wr_data", write_data, 32'hABCD_2222);
        check("sh_wr_addr", addr, 32'h2000);
        complete(32'h0);
        check("sh_wr_drop", write_mem, 0);
        check("sh_wb_valid", wb_valid, 1);
        check("sh_wb_rd", wb_rd, 0);
        check("sh_wb_data", wb_data, 0);
        check("sh_wb_exc", wb_exc, EXC_NONE);
        handshake();

        // SB ea=0x6001 merges lane 1
        issue(1'b1, F3_B, 32'h6000, 32'd1, 32'h1234_565A, 5'd3);
        complete(32'hAABB_CCDD);
        tick();
        check("sb_wr_data", write_data, 32'hAABB_5ADD);
        complete(32'h0);
        check("sb_wb_exc", wb_exc, EXC_NONE);
        handshake();

        // LW ea=0x3001
        issue(1'b0, F3_W, 32'h3000, 32'd1, 32'h0, 5'd9);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw_mis_read", read_mem, 0);
        check("lw_mis_write", write_mem, 0);
        check("lw_mis_valid", wb_valid, 1);
        check("lw_mis_exc", wb_exc, EXC_MISALIGN);
        check("lw_mis_rd", wb_rd, 0);
`else
        check("lw_al_read", read_mem, 1);
        check("lw_al_addr", addr, 32'h3000);
        complete(32'hDEAD_BEEF);
        check("lw_al_data", wb_data, 32'hDEAD_BEEF);
        check("lw_al_exc", wb_exc, EXC_NONE);
        check("lw_al_rd", wb_rd, 9);
`endif
        handshake();

        // illegal load funct3
        issue(1'b0, 3'b011, 32'h100, 32'd0, 32'h0, 5'd4);
        check("ill_read", read_mem, 0);
        check("ill_valid", wb_valid, 1);
        check("ill_exc", wb_exc, EXC_ILLEGAL);
        check("ill_rd", wb_rd, 0);
        handshake();

        // SW with no mem_done: 16 WR cycles then timeout
        issue(1'b1, F3_W, 32'h4000, 32'd0, 32'h1234_5678, 5'd2);
        check("sw_first_data", write_data, 32'h1234_5678);
        n = 0;
        while (write_mem === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check("sw_tmo_cycles", n, 16);
        check("sw_tmo_av", addr_valid, 0);
        check("sw_tmo_wdv", write_data_valid, 0);
        check("sw_tmo_valid", wb_valid, 1);
        check("sw_tmo_exc", wb_exc, EXC_TIMEOUT);
        check("sw_tmo_rd", wb_rd, 0);
        handshake();

        // LHU held in WB by wb_ready=0
        issue(1'b0, F3_HU, 32'h5000, 32'd2, 32'h0, 5'd11);
        complete(32'h8001_7FFF);
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("lhu_hold_valid", wb_valid, 1);
            check("lhu_hold_data", wb_data, 32'h0000_8001);
            check("lhu_hold_ready", req_ready, 0);
            tick();
        end
        req_valid = 1'b0;
        check("lhu_rd", wb_rd, 11);
        handshake();
        check("lhu_after_valid", wb_valid, 0);
        check("lhu_after_ready", req_ready, 1);

        // async reset in the middle of RD
        issue(1'b0, F3_W, 32'h7000, 32'd0, 32'h0, 5'd1);
        check("rst_mid_read_pre", read_mem, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_read", read_mem, 0);
        check("rst_mid_av", addr_valid, 0);
        check("rst_mid_busy", busy, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_rel_ready", req_ready, 1);
        check("rst_rel_wb", wb_valid, 0);
        tick();
        check("rst_rel_wb2", wb_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store stage directly upstream of the data-cache AXI controller in the scoreboard RISC core.
- Accepts one memory op from issue and computes the effective address (base+offset). Checks alignment, then drives the controller's level-style request (read_mem/write_mem, addr, addr_valid, write_data) until mem_done.
- Loads are lane-extracted and sign/zero-extended. SB/SH are done as read-modify-write because the downstream block writes whole words only.
- Results and store completions go to the writeback/scoreboard through a valid/ready port.

Parameters:
- TIMEOUT_CYCLES, 256: maximum cycles spent in RD or WR without mem_done before the op is aborted with a bus error.
- TMO_W, 9: timeout counter width, at least clog2(TIMEOUT_CYCLES)+1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  issue request valid
- req_ready  out  1  high only in IDLE
- req_is_store  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3
- req_base  in  32  rs1 value
- req_offset  in  32  sign-extended immediate
- req_wdata  in  32  rs2 value (stores)
- req_rd  in  5  destination register tag
- read_mem  out  1  read request level to controller
- write_mem  out  1  write request level to controller
- addr  out  32  word-aligned address {ea[31:2],2'b00}
- addr_valid  out  1  address valid to controller
- write_data  out  32  full word to write
- write_data_valid  out  1  write data valid
- mem_done  in  1  controller completion, combinational from controller
- result  in  32  read word from controller
- wb_valid  out  1  completion valid
- wb_ready  in  1  writeback accepts
- wb_rd  out  5  destination tag; 0 for stores and faults
- wb_data  out  32  load result; 0 for stores
- wb_exc  out  2  00 ok, 01 misaligned, 10 bus timeout, 11 illegal funct3
- busy  out  1  state != IDLE

Behaviour:
- Reset: every registered output is 0 and the FSM returns to IDLE immediately (async). Any in-flight op is dropped with no writeback.
- Accept: req_valid & req_ready at a rising edge latches ea=req_base+req_offset (mod 2^32), funct3, is_store, wdata and rd.
- Load decode: LB 000, LH 001, LW 010, LBU 100, LHU 101. Any other funct3 gives exc 11.
- Store decode: SB 000, SH 001, SW 010. Any other funct3 gives exc 11.
- Alignment: a halfword with ea[0]=1, or a word with ea[1:0]!=0, is misaligned (exc 01). No bus access is made.
- FSM states: IDLE, RD, GAP, WR, WB.
- IDLE transitions: illegal or misaligned op goes to WB. LW/LH/LB/LHU/LBU and SB/SH go to RD. SW goes to WR.
- RD outputs: read_mem=1, addr_valid=1, addr word-aligned.
- RD on mem_done: capture result into word_q and drop read_mem/addr_valid on the next edge. A load goes to WB; a store goes to GAP.
- GAP: exactly one cycle with read_mem=write_mem=addr_valid=0, so the controller returns to idle. The merged word is computed here.
  - SB replaces byte lane ea[1:0] with wdata[7:0].
  - SH replaces half lane ea[1] with wdata[15:0].
  - GAP then goes to WR.
- WR outputs: write_mem=1, addr_valid=1, write_data_valid=1, write_data = merged word (SW: wdata). On mem_done go to WB.
- Load extraction: lane selected by ea[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- Latency: a load completes its wb one cycle after mem_done.
- Timeout counter:
  - Cleared on entry to RD or WR and increments every cycle in those states.
  - When it reaches TIMEOUT_CYCLES-1 without mem_done, all request outputs are deasserted and the op goes to WB with exc 10.
  - This covers bresp!=OKAY, which never raises mem_done.
- WB: wb_valid=1 and wb fields are held stable until wb_ready. On the handshake go to IDLE; req_ready rises the next cycle.
- Simultaneous events: mem_done in the same cycle as timeout expiry counts as success.
- mem_done outside RD/WR is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned ops complete with exc 01 and no bus traffic, as described above.
- Undefined: no misalignment detection. Low address bits are forced to natural alignment (halfword clears ea[0], word clears ea[1:0]). The op proceeds normally and exc 01 is never produced.

Decomposition:
- Shared package lsu_pkg holds:
  - the funct3 constants;
  - the exc codes (EXC_NONE, EXC_MISALIGN, EXC_TIMEOUT, EXC_ILLEGAL);
  - the state encoding (IDLE..WB).
- One sub-module, lsu_lane_unit, is combinational and contains:
  - load extract/extend (word, ea[1:0], funct3 -> data);
  - store merge (old word, wdata, ea[1:0], funct3 -> word).

Test Plan:
- LB with base=0x1000, offset=3, memory word 0x80FF_1234 -> read at addr 0x1000, wb_data=0xFFFF_FF80, wb_rd=req_rd, exc 00.
- SH with ea=0x2002, wdata=0xABCD, old word 0x1111_2222 -> RD then one GAP cycle, then WR with write_data=0xABCD_2222, then wb_rd=0, exc 00.
- LW with ea=0x3001:
  - macro defined -> no read_mem/write_mem pulse, exc 01;
  - macro undefined -> read of 0x3000 with a normal result.
- SW where the controller never raises mem_done (bresp=2'b10), TIMEOUT_CYCLES=16 -> write_mem drops after 16 WR cycles, exc 10.
- LHU completes while wb_ready is held 0 for 5 cycles -> wb_valid and wb_data=0x0000_8001 stay stable and req_ready stays 0 until the handshake.
- rst_n asserted low in the middle of RD -> read_mem=addr_valid=0 immediately. After release: IDLE, req_ready=1, no wb_valid.
